rest_wb_bridge: RTL and testbench

// - Wishbone classic slave inside rest_top, directly downstream of the user_project_wrapper wbs_* pins.
// - Converts CPU bus accesses into a CSR bank plus two streaming FIFOs feeding and draining the REST core.
// - TX FIFO carries CPU->core words; RX FIFO carries core->CPU words.
// - Drives irq[0] to user_irq[0].

---
 rtl/rest_pkg.sv | 38 +++
 rtl/rest_sync_fifo.sv | 59 +++++
 rtl/rest_wb_bridge.sv | 170 +++++++++++++++++
 tb/tb_rest_wb_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rest_pkg.sv
// Shared constants for the REST Wishbone bridge: CSR offsets, IRQ bit
// positions and STATUS field layout.
package rest_pkg;

   // Word offsets, taken from wbs_adr_i[4:2]
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_STATUS   = 3'd1;
   localparam logic [2:0] REG_TXDATA   = 3'd2;
   localparam logic [2:0] REG_RXDATA   = 3'd3;
   localparam logic [2:0] REG_IRQ_EN   = 3'd4;
   localparam logic [2:0] REG_IRQ_STAT = 3'd5;

   localparam int IRQ_W        = 4;
   localparam int IRQ_RX_AVAIL = 0;
   localparam int IRQ_TX_OVF   = 1;
   localparam int IRQ_RX_UDF   = 2;
   localparam int IRQ_TX_DONE  = 3;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_TX_FLUSH = 1;
   localparam int CTRL_RX_FLUSH = 2;

   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_LVL   = 8;
   localparam int ST_RX_LVL   = 16;

   // One-cycle command strobes derived from a CPU access
   typedef struct packed {
      logic tx_push;
      logic rx_pop;
      logic tx_flush;
      logic rx_flush;
   } fifo_cmd_t;

endpackage

// File: rtl/rest_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head is combinational
// from storage so the consumer sees data in the same cycle it is valid.
module rest_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [DW-1:0]            head
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   // Flush dominates; a push while full is refused even if a pop frees a slot
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/rest_wb_bridge.sv
// Wishbone classic slave exposing a small CSR bank and two streaming FIFOs
// (CPU->core TX, core->CPU RX) with a level interrupt on irq_o[0].
module rest_wb_bridge
   import rest_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          DW         = 32
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   input  logic [3:0]    wbs_sel_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic          tx_valid_o,
   output logic [DW-1:0] tx_data_o,
   input  logic          tx_ready_i,
   input  logic          rx_valid_i,
   input  logic [DW-1:0] rx_data_i,
   output logic          rx_ready_o,
   output logic [2:0]    irq_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic            hit, ack_q, acc, wr, rd;
   logic [2:0]      off;
   fifo_cmd_t       cmd;
   logic            ctrl_wr, en_wr;
   logic            enable_q;
   logic [IRQ_W-1:0] irq_en_q, irq_stat_q, irq_set, irq_clr;
   logic            tx_empty_d;
   logic            tx_full, tx_empty, rx_full, rx_empty;
   logic [LW-1:0]   tx_level, rx_level;
   logic [DW-1:0]   tx_head, rx_head;
   logic            tx_pop, rx_push;
   logic [31:0]     status, rdata;
   logic            sel_unused;

   assign sel_unused = &{1'b0, wbs_sel_i[3:1]};

   // ---------------------------------------------------------------- bus
   assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign off = wbs_adr_i[4:2];

   // Ack toggles low for one cycle between beats, so a held strobe
   // completes one access every two cycles.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) ack_q <= 1'b0;
      else            ack_q <= hit & ~ack_q;
   end

   assign wbs_ack_o = ack_q;
   assign acc       = ack_q & hit;
   assign wr        = acc & wbs_we_i;
   assign rd        = acc & ~wbs_we_i;

   // ---------------------------------------------------------------- commands
   assign ctrl_wr = wr & (off == REG_CTRL) & wbs_sel_i[0];
   assign en_wr   = wr & (off == REG_IRQ_EN) & wbs_sel_i[0];

   always_comb begin
      cmd          = '0;
      cmd.tx_push  = wr & (off == REG_TXDATA);
      cmd.rx_pop   = rd & (off == REG_RXDATA);
      cmd.tx_flush = ctrl_wr & wbs_dat_i[CTRL_TX_FLUSH];
      cmd.rx_flush = ctrl_wr & wbs_dat_i[CTRL_RX_FLUSH];
   end

   // ---------------------------------------------------------------- streams
   assign tx_valid_o = enable_q & ~tx_empty;
   assign rx_ready_o = enable_q & ~rx_full;
   assign tx_pop     = tx_valid_o & tx_ready_i;
   assign rx_push    = rx_valid_i & rx_ready_o;
   assign tx_data_o  = tx_head;

   rest_sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_tx_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (cmd.tx_push),
      .push_data (DW'(wbs_dat_i)),
      .pop       (tx_pop),
      .flush     (cmd.tx_flush),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (tx_level),
      .head      (tx_head)
   );

   rest_sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_rx_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (rx_push),
      .push_data (rx_data_i),
      .pop       (cmd.rx_pop),
      .flush     (cmd.rx_flush),
      .full      (rx_full),
      .empty     (rx_empty),
      .level     (rx_level),
      .head      (rx_head)
   );

   // ---------------------------------------------------------------- CSRs
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         enable_q <= 1'b0;
         irq_en_q <= '0;
      end else begin
         if (ctrl_wr) enable_q <= wbs_dat_i[CTRL_ENABLE];
         if (en_wr)   irq_en_q <= wbs_dat_i[IRQ_W-1:0];
      end
   end

   // tx_done is an edge detector on tx_empty, so any route to empty counts
   always_comb begin
      irq_set               = '0;
      irq_set[IRQ_RX_AVAIL] = rx_push & ~cmd.rx_flush;
      irq_set[IRQ_TX_OVF]   = cmd.tx_push & tx_full & ~cmd.tx_flush;
      irq_set[IRQ_RX_UDF]   = cmd.rx_pop & rx_empty;
      irq_set[IRQ_TX_DONE]  = tx_empty & ~tx_empty_d;
   end

   assign irq_clr = (wr && off == REG_IRQ_STAT && wbs_sel_i[0]) ?
                    wbs_dat_i[IRQ_W-1:0] : '0;

   // Hardware set wins over a simultaneous W1C
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         irq_stat_q <= '0;
         tx_empty_d <= 1'b1;
      end else begin
         irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
         tx_empty_d <= tx_empty;
      end
   end

   assign irq_o = {2'b00, |(irq_stat_q & irq_en_q)};

   // ---------------------------------------------------------------- readback
   always_comb begin
      status                     = '0;
      status[ST_TX_EMPTY]        = tx_empty;
      status[ST_TX_FULL]         = tx_full;
      status[ST_RX_EMPTY]        = rx_empty;
      status[ST_RX_FULL]         = rx_full;
      status[ST_TX_LVL +: LW]    = tx_level;
      status[ST_RX_LVL +: LW]    = rx_level;
   end

   always_comb begin
      rdata = '0;
      unique case (off)
         REG_CTRL:     rdata[CTRL_ENABLE] = enable_q;
         REG_STATUS:   rdata = status;
         REG_RXDATA:   rdata = rx_empty ? '0 : 32'(rx_head);
         REG_IRQ_EN:   rdata[IRQ_W-1:0] = irq_en_q;
         REG_IRQ_STAT: rdata[IRQ_W-1:0] = irq_stat_q;
         default:      rdata = '0;
      endcase
   end

   assign wbs_dat_o = ack_q ? rdata : '0;

endmodule

// File: tb/tb_rest_wb_bridge.sv
// Directed self-checking bench for rest_wb_bridge.
module tb_rest_wb_bridge;

   localparam logic [31:0] A_CTRL     = 32'h3000_0000;
   localparam logic [31:0] A_STATUS   = 32'h3000_0004;
   localparam logic [31:0] A_TXDATA   = 32'h3000_0008;
   localparam logic [31:0] A_RXDATA   = 32'h3000_000C;
   localparam logic [31:0] A_IRQ_EN   = 32'h3000_0010;
   localparam logic [31:0] A_IRQ_STAT = 32'h3000_0014;
   localparam logic [31:0] A_OTHER    = 32'h3000_001C;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
   logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
   logic [3:0]  wbs_sel_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        tx_valid_o, tx_ready_i = 1'b0;
   logic [31:0] tx_data_o;
   logic        rx_valid_i = 1'b0, rx_ready_o;
   logic [31:0] rx_data_i = '0;
   logic [2:0]  irq_o;

   int checks = 0;
   int failures = 0;
   logic [31:0] rd;

   always #5 wb_clk_i = ~wb_clk_i;

   rest_wb_bridge dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
      .irq_o(irq_o)
   );

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdata);
      bit got = 0;
      rdata = '0;
      wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int n = 0; n < 8 && !got; n++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) begin got = 1; rdata = wbs_dat_o; end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL wb_ack adr=%h: no ack within 8 cycles", adr);
      end else begin
         @(posedge wb_clk_i); #1;
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] dummy;
      wb_access(adr, 1'b1, dat, 4'hF, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata);
      wb_access(adr, 1'b0, 32'h0, 4'hF, rdata);
   endtask

   task automatic test_reset;
      wb_rst_ni = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      checks++; if (wbs_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", wbs_ack_o); end
      checks++; if (wbs_dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h exp=0", wbs_dat_o); end
      checks++; if (irq_o !== 3'b000) begin failures++; $display("FAIL rst_irq got=%b exp=000", irq_o); end
      checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid_o); end
      checks++; if (rx_ready_o !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready_o); end
      checks++; if (tx_data_o !== 32'h0) begin failures++; $display("FAIL rst_tx_data got=%h exp=0", tx_data_o); end
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0000_0005) begin failures++; $display("FAIL rst_status got=%h exp=00000005", rd); end
      wb_read(A_CTRL, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_irq_stat got=%h exp=0", rd); end
   endtask

   task automatic test_tx_stream;
      logic [31:0] exp_w [3];
      exp_w[0] = 32'hA5A5_0001; exp_w[1] = 32'hA5A5_0002; exp_w[2] = 32'hA5A5_0003;
      wb_write(A_CTRL, 32'h1);
      checks++; if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL en_rx_ready got=%b exp=1", rx_ready_o); end
      checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL en_tx_valid_empty got=%b exp=0", tx_valid_o); end
      for (int i = 0; i < 3; i++) wb_write(A_TXDATA, exp_w[i]);
      tx_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_valid_o !== 1'b1 || tx_data_o !== exp_w[i]) begin
            failures++;
            $display("FAIL tx_word%0d got valid=%b data=%h exp valid=1 data=%h", i, tx_valid_o, tx_data_o, exp_w[i]);
         end
         @(posedge wb_clk_i); #1;
      end
      checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL tx_drained got=%b exp=0", tx_valid_o); end
      tx_ready_i = 1'b0;
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h8) begin failures++; $display("FAIL tx_done_stat got=%h exp=8", rd); end
      wb_write(A_IRQ_STAT, 32'hF);
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=0", rd); end
   endtask

   task automatic test_overflow;
      int cnt = 0;
      for (int i = 0; i < 9; i++) wb_write(A_TXDATA, 32'h100 + i);
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0000_0806) begin failures++; $display("FAIL ovf_status got=%h exp=00000806", rd); end
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h2) begin failures++; $display("FAIL ovf_stat got=%h exp=2", rd); end
      checks++; if (irq_o !== 3'b000) begin failures++; $display("FAIL irq_masked got=%b exp=000", irq_o); end
      wb_write(A_IRQ_EN, 32'h2);
      wb_read(A_IRQ_EN, rd);
      checks++; if (rd !== 32'h2) begin failures++; $display("FAIL irq_en_rb got=%h exp=2", rd); end
      checks++; if (irq_o !== 3'b001) begin failures++; $display("FAIL irq_on got=%b exp=001", irq_o); end
      wb_write(A_IRQ_STAT, 32'h2);
      checks++; if (irq_o !== 3'b000) begin failures++; $display("FAIL irq_off got=%b exp=000", irq_o); end
      tx_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (tx_valid_o) begin
            checks++;
            if (tx_data_o !== 32'h100 + cnt) begin
               failures++;
               $display("FAIL ovf_drain%0d got=%h exp=%h", cnt, tx_data_o, 32'h100 + cnt);
            end
            cnt++;
         end
         @(posedge wb_clk_i); #1;
      end
      tx_ready_i = 1'b0;
      checks++; if (cnt != 8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", cnt); end
      wb_write(A_IRQ_STAT, 32'hF);
   endtask

   task automatic test_rx;
      checks++; if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b exp=1", rx_ready_o); end
      rx_valid_i = 1'b1; rx_data_i = 32'h1234;
      @(posedge wb_clk_i); #1;
      rx_valid_i = 1'b0; rx_data_i = '0;
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0001_0001) begin failures++; $display("FAIL rx_status got=%h exp=00010001", rd); end
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rx_avail got=%h exp=1", rd); end
      wb_read(A_RXDATA, rd);
      checks++; if (rd !== 32'h1234) begin failures++; $display("FAIL rx_pop got=%h exp=00001234", rd); end
      wb_read(A_RXDATA, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rx_pop_empty got=%h exp=0", rd); end
      wb_read(A_IRQ_STAT, rd);
      checks++; if (rd !== 32'h5) begin failures++; $display("FAIL rx_udf got=%h exp=5", rd); end
      wb_write(A_IRQ_STAT, 32'hF);
   endtask

   task automatic test_no_hit;
      bit seen = 0;
      wbs_adr_i = 32'h3001_0008; wbs_we_i = 1'b1; wbs_dat_i = 32'hDEAD; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (10) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) seen = 1;
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      checks++; if (seen) begin failures++; $display("FAIL nohit_ack got=1 exp=0"); end
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h5) begin failures++; $display("FAIL nohit_status got=%h exp=5", rd); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] pat;
      wbs_adr_i = A_TXDATA; wbs_we_i = 1'b1; wbs_dat_i = 32'hB0B0_0000; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      pat[3] = wbs_ack_o;
      for (int i = 2; i >= 0; i--) begin
         @(posedge wb_clk_i); #1;
         pat[i] = wbs_ack_o;
      end
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      checks++; if (pat !== 4'b0101) begin failures++; $display("FAIL b2b_ack got=%b exp=0101", pat); end
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0000_0204) begin failures++; $display("FAIL b2b_status got=%h exp=00000204", rd); end
      checks++; if (tx_data_o !== 32'hB0B0_0000) begin failures++; $display("FAIL b2b_head got=%h exp=b0b00000", tx_data_o); end
   endtask

   task automatic test_flush;
      bit got = 0;
      wb_write(A_TXDATA, 32'hC);
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0000_0304) begin failures++; $display("FAIL pre_flush_status got=%h exp=00000304", rd); end
      // CTRL write with both flushes lands in the same edge as a core RX push
      wbs_adr_i = A_CTRL; wbs_we_i = 1'b1; wbs_dat_i = 32'h7; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int n = 0; n < 8 && !got; n++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) got = 1;
      end
      checks++; if (!got) begin failures++; $display("FAIL flush_ack got=0 exp=1"); end
      checks++; if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL flush_rx_ready got=%b exp=1", rx_ready_o); end
      rx_valid_i = 1'b1; rx_data_i = 32'h5555;
      @(posedge wb_clk_i); #1;
      rx_valid_i = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h5) begin failures++; $display("FAIL flush_status got=%h exp=5", rd); end
      wb_read(A_CTRL, rd);
      checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ctrl_selfclear got=%h exp=1", rd); end
      wb_write(A_IRQ_STAT, 32'hF);
      wb_access(A_CTRL, 1'b1, 32'h0, 4'b1110, rd);
      wb_read(A_CTRL, rd);
      checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ctrl_sel0 got=%h exp=1", rd); end
      wb_write(A_OTHER, 32'hFFFF_FFFF);
      wb_read(A_OTHER, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL other_off got=%h exp=0", rd); end
      wb_read(A_TXDATA, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL txdata_rd got=%h exp=0", rd); end
   endtask

   task automatic test_reset_mid_ack;
      bit got = 0;
      wb_write(A_TXDATA, 32'hD);
      checks++; if (tx_valid_o !== 1'b1) begin failures++; $display("FAIL pre_rst_tx_valid got=%b exp=1", tx_valid_o); end
      wbs_adr_i = A_STATUS; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int n = 0; n < 8 && !got; n++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) got = 1;
      end
      checks++; if (!got) begin failures++; $display("FAIL mid_ack_seen got=0 exp=1"); end
      #2 wb_rst_ni = 1'b0;
      #1;
      checks++; if (wbs_ack_o !== 1'b0) begin failures++; $display("FAIL async_ack got=%b exp=0", wbs_ack_o); end
      checks++; if (wbs_dat_o !== 32'h0) begin failures++; $display("FAIL async_dat got=%h exp=0", wbs_dat_o); end
      checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL async_tx_valid got=%b exp=0", tx_valid_o); end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge wb_clk_i); #1;
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      wb_read(A_STATUS, rd);
      checks++; if (rd !== 32'h5) begin failures++; $display("FAIL post_rst_status got=%h exp=5", rd); end
      wb_read(A_CTRL, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_rst_ctrl got=%h exp=0", rd); end
   endtask

   initial begin
      test_reset;
      test_tx_stream;
      test_overflow;
      test_rx;
      test_no_hit;
      test_back_to_back;
      test_flush;
      test_reset_mid_ack;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
